// File: rtl/gpu_pixel_pkg.sv
// Shared pixel-path definitions: pixel word field positions, default screen
// bounds and the write-arbiter state encoding.
package gpu_pixel_pkg;

   localparam int PIX_X_MSB      = 63;
   localparam int PIX_X_LSB      = 48;
   localparam int PIX_Y_MSB      = 47;
   localparam int PIX_Y_LSB      = 32;
   localparam int PIX_COLOUR_MSB = 31;

   localparam int SCREEN_W_DEF = 640;
   localparam int SCREEN_H_DEF = 480;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/pixel_write_arbiter_rr_pick.sv
// Rotated priority encoder: first asserted req_valid at or after rr_ptr,
// wrapping modulo N. Purely combinational.
module rr_pick #(
   parameter int N = 3,
   parameter int W = 2
) (
   input  logic [N-1:0] req_valid,
   input  logic [W-1:0] rr_ptr,
   output logic         hit,
   output logic [W-1:0] index
);

   logic [W:0] cand;

   // Scan from the farthest offset down so the nearest hit is written last.
   always_comb begin
      hit   = 1'b0;
      index = '0;
      cand  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr} + (W + 1)'(k);
         if (cand >= (W + 1)'(N)) begin
            cand = cand - (W + 1)'(N);
         end
         if (req_valid[cand[W-1:0]]) begin
            hit   = 1'b1;
            index = cand[W-1:0];
         end
      end
   end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Round-robin, burst-bounded arbiter feeding the framebuffer pixel-write FIFO.
// Optional PIXEL_WRITE_ARBITER_CLIP_EN drops off-screen pixels and counts them.
//
// state     | meaning
// ARB_IDLE  | searching req_valid from rr_ptr, req_ready all low
// ARB_GRANT | grant_id owns the FIFO until burst limit or source goes idle
module pixel_write_arbiter
   import gpu_pixel_pkg::*;
#(
   parameter int NUM_REQ   = 3,
   parameter int BURST_MAX = 16
`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
   ,
   parameter int SCREEN_W  = SCREEN_W_DEF,
   parameter int SCREEN_H  = SCREEN_H_DEF
`endif
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [NUM_REQ*64-1:0]     req_pixel_data,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [63:0]               out_pixel_data,
   output logic                      out_valid,
   input  logic                      out_fifo_full,
   output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
   output logic                      busy
`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
   ,
   output logic [15:0]               clip_count
`endif
);

   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(BURST_MAX + 1);

   arb_state_t    state, state_nxt;
   logic [GW-1:0] rr_ptr, rr_ptr_nxt, grant_id_nxt;
   logic [CW-1:0] burst_cnt, burst_cnt_nxt;
   logic          pick_hit;
   logic [GW-1:0] pick_idx;
   logic [63:0]   grant_word;
   logic          accept, emit;

   rr_pick #(.N(NUM_REQ), .W(GW)) u_rr_pick (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr),
      .hit       (pick_hit),
      .index     (pick_idx)
   );

   assign grant_word = req_pixel_data[64*grant_id +: 64];
   assign busy       = (state == ARB_GRANT);

   always_comb begin
      state_nxt     = state;
      rr_ptr_nxt    = rr_ptr;
      grant_id_nxt  = grant_id;
      burst_cnt_nxt = burst_cnt;
      req_ready     = '0;
      accept        = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (pick_hit) begin
               grant_id_nxt  = pick_idx;
               burst_cnt_nxt = '0;
               state_nxt     = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            // Gated by reset_n so no handshake can complete in a reset cycle.
            req_ready[grant_id] = !out_fifo_full && reset_n;
            accept = req_valid[grant_id] && !out_fifo_full && reset_n;
            if (accept) begin
               burst_cnt_nxt = burst_cnt + 1'b1;
            end
            if ((accept && (burst_cnt == CW'(BURST_MAX - 1))) ||
                (!req_valid[grant_id] && !out_fifo_full)) begin
               state_nxt  = ARB_IDLE;
               rr_ptr_nxt = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
   logic clipped;
   assign clipped = (int'(grant_word[PIX_X_MSB:PIX_X_LSB]) >= SCREEN_W) ||
                    (int'(grant_word[PIX_Y_MSB:PIX_Y_LSB]) >= SCREEN_H);
   assign emit    = accept && !clipped;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         clip_count <= '0;
      end else if (accept && clipped && (clip_count != 16'hFFFF)) begin
         clip_count <= clip_count + 16'd1;
      end
   end
`else
   assign emit = accept;
`endif

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state          <= ARB_IDLE;
         rr_ptr         <= '0;
         grant_id       <= '0;
         burst_cnt      <= '0;
         out_valid      <= 1'b0;
         out_pixel_data <= '0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_ptr_nxt;
         grant_id  <= grant_id_nxt;
         burst_cnt <= burst_cnt_nxt;
         out_valid <= emit;
         if (emit) begin
            out_pixel_data <= grant_word;
         end
      end
   end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Randomised bench for pixel_write_arbiter against a cycle-level behavioural
// model of the round-robin burst rules.
module tb_pixel_write_arbiter;

   localparam int N  = 3;
   localparam int BM = 4;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic [N*64-1:0]   req_pixel_data = '0;
   logic [N-1:0]      req_valid = '0;
   logic [N-1:0]      req_ready;
   logic [63:0]       out_pixel_data;
   logic              out_valid;
   logic              out_fifo_full = 1'b0;
   logic [1:0]        grant_id;
   logic              busy;
`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
   logic [15:0]       clip_count;
`endif

   always #5 clock = ~clock;

   pixel_write_arbiter #(.NUM_REQ(N), .BURST_MAX(BM)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .req_pixel_data (req_pixel_data),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .out_pixel_data (out_pixel_data),
      .out_valid      (out_valid),
      .out_fifo_full  (out_fifo_full),
      .grant_id       (grant_id),
      .busy           (busy)
`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
      ,
      .clip_count     (clip_count)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Sources hold a pending word until the model says it was consumed.
   logic [63:0] src_word [N];
   bit          src_pend [N];

   // Behavioural model: owner < 0 means nobody holds the FIFO.
   int          m_owner = -1;
   int          m_grant = 0;
   int          m_ptr   = 0;
   int          m_cnt   = 0;
   bit          m_ov    = 1'b0;
   logic [63:0] m_data  = '0;
   int          m_clip  = 0;

   function automatic logic [63:0] new_word();
      logic [15:0] x, y;
      x = 16'($urandom_range(0, 700));
      y = 16'($urandom_range(0, 520));
      return {x, y, 32'($urandom)};
   endfunction

   task automatic model_reset();
      m_owner = -1; m_grant = 0; m_ptr = 0; m_cnt = 0;
      m_ov = 1'b0; m_data = '0; m_clip = 0;
   endtask

   task automatic run_cycle(input int load_pct, input logic [N-1:0] mask,
                            input int full_pct, input bit rst);
      logic [N-1:0] exp_ready;
      bit           full, v, acc;
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
         if (!src_pend[i] && mask[i] && ($urandom_range(0, 99) < load_pct)) begin
            src_pend[i] = 1'b1;
            src_word[i] = new_word();
         end
         req_valid[i] = src_pend[i];
         req_pixel_data[64*i +: 64] = src_word[i];
      end
      full = ($urandom_range(0, 99) < full_pct);
      out_fifo_full = full;
      reset_n = !rst;
      #1;
      exp_ready = '0;
      if (m_owner >= 0 && !full && !rst) exp_ready[m_owner] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("busy", 64'(busy), 64'(m_owner >= 0));
      chk("grant_id", 64'(grant_id), 64'(m_grant));
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("out_pixel_data", out_pixel_data, m_data);
`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
      chk("clip_count", 64'(clip_count), 64'(m_clip));
`endif
      if (rst) begin
         model_reset();
      end else if (m_owner < 0) begin
         m_ov = 1'b0;
         for (int k = 0; k < N; k++) begin
            if (m_owner < 0 && src_pend[(m_ptr + k) % N]) begin
               m_owner = (m_ptr + k) % N;
               m_grant = m_owner;
               m_cnt   = 0;
            end
         end
      end else begin
         v   = src_pend[m_owner];
         acc = v && !full;
         m_ov = 1'b0;
         if (acc) begin
            m_cnt++;
            src_pend[m_owner] = 1'b0;
`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
            if (src_word[m_owner][63:48] >= 16'd640 || src_word[m_owner][47:32] >= 16'd480) begin
               if (m_clip < 65535) m_clip++;
            end else begin
               m_ov = 1'b1;
               m_data = src_word[m_owner];
            end
`else
            m_ov = 1'b1;
            m_data = src_word[m_owner];
`endif
         end
         if ((acc && m_cnt == BM) || (!v && !full)) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         src_pend[i] = 1'b0;
         src_word[i] = '0;
      end
      model_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      // Single source back-to-back, then all sources saturating.
      for (int c = 0; c < 12; c++) run_cycle(100, 3'b001, 0, 1'b0);
      for (int c = 0; c < 30; c++) run_cycle(100, 3'b111, 0, 1'b0);
      // Long stall in the middle of a burst.
      for (int c = 0; c < 2; c++)  run_cycle(100, 3'b111, 0, 1'b0);
      for (int c = 0; c < 10; c++) run_cycle(100, 3'b111, 100, 1'b0);
      for (int c = 0; c < 10; c++) run_cycle(100, 3'b111, 0, 1'b0);
      // Source 1 goes quiet while source 2 keeps requesting.
      for (int c = 0; c < 20; c++) run_cycle(100, 3'b110, 0, 1'b0);
      for (int c = 0; c < 20; c++) run_cycle(60, 3'b100, 0, 1'b0);
      // Reset in the middle of a burst.
      for (int c = 0; c < 3; c++)  run_cycle(100, 3'b111, 0, 1'b0);
      run_cycle(100, 3'b111, 0, 1'b1);
      for (int c = 0; c < 20; c++) run_cycle(100, 3'b111, 0, 1'b0);
      // Random traffic with random backpressure and occasional resets.
      for (int c = 0; c < 800; c++) begin
         run_cycle($urandom_range(10, 100), 3'($urandom_range(1, 7)),
                   $urandom_range(0, 40), ($urandom_range(0, 199) == 0));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pixel_write_arbiter.md
Name: pixel_write_arbiter

Overview:
- Shares the single framebuffer pixel-write FIFO between up to NUM_REQ pixel sources: the rasteriser line drawer, a framebuffer clear engine and a host direct-write path.
- Each source presents 64-bit pixel words laid out as x[63:48], y[47:32], colour[31:0].
- Round-robin arbitration with bounded bursts, one registered output stage, and backpressure from the downstream FIFO full flag.

Parameters:
- NUM_REQ, 3, number of pixel sources (2..8)
- BURST_MAX, 16, maximum pixels accepted per grant before forced rotation (1..256)
- SCREEN_W, 640, horizontal pixel bound used by clip logic
- SCREEN_H, 480, vertical pixel bound used by clip logic

Ports:
- clock  in  1  core clock, all logic posedge
- reset_n  in  1  reset, synchronous, active-low
- req_pixel_data  in  NUM_REQ*64  source i pixel word at bits [64*i+63:64*i]
- req_valid  in  NUM_REQ  source i has a pixel
- req_ready  out  NUM_REQ  source i pixel consumed this cycle when req_valid[i] & req_ready[i]
- out_pixel_data  out  64  registered pixel to framebuffer FIFO
- out_valid  out  1  write strobe, one cycle per pixel
- out_fifo_full  in  1  downstream FIFO full; asserts with at least 1 free entry of headroom
- grant_id  out  clog2(NUM_REQ) (min 1)  currently or last granted source
- busy  out  1  high while the FSM is in GRANT

Behaviour:
- Reset (reset_n low at posedge) forces these values:
  - out_valid=0, out_pixel_data=0, req_ready=0, grant_id=0, busy=0.
  - FSM=IDLE, rr_ptr=0, burst_cnt=0.
  - A pixel in the output register is discarded. Reset mid-burst drops the grant without completing it.
- FSM IDLE:
  - Search req_valid in rotated order starting at rr_ptr.
  - On the first hit i: grant_id<=i, burst_cnt<=0, go to GRANT.
  - No hit: remain in IDLE.
  - Arbitration latency is 1 cycle (the IDLE cycle). req_ready is all-zero in IDLE.
- FSM GRANT:
  - req_ready[grant_id] = !out_fifo_full, combinational. All other req_ready bits are 0.
  - Accept = req_valid[grant_id] & req_ready[grant_id].
  - On accept: out_pixel_data<=word and out_valid<=1 next cycle; burst_cnt increments. Otherwise out_valid<=0 next cycle.
  - Cycles with out_fifo_full high do not advance burst_cnt and do not release the grant.
  - Release to IDLE, with rr_ptr<=(grant_id+1) mod NUM_REQ, when either:
    - the accept makes burst_cnt reach BURST_MAX, or
    - req_valid[grant_id] is low while out_fifo_full is low (source idle).
  - Release and accept can coincide; the accepted pixel is still emitted.
- Throughput is 1 pixel/cycle within a burst. Rotation costs 1 idle cycle.
- Ordering: pixels from one source leave in acceptance order. No interleaving of sources inside a burst.
- Starvation bound: with all sources valid, each source waits at most (NUM_REQ-1)*(BURST_MAX+1) unstalled cycles.
- req_pixel_data is sampled only on accept. Sources must hold data and valid stable until accepted.
- Out-of-range requester indices cannot occur: the rotation wraps modulo NUM_REQ for non-power-of-2 counts.

Optional Feature:
- Macro: PIXEL_WRITE_ARBITER_CLIP_EN.
- Defined:
  - An accepted pixel with x >= SCREEN_W or y >= SCREEN_H is consumed (req_ready handshake completes, burst_cnt increments) but out_valid stays 0 for it.
  - A 16-bit saturating counter clip_count (extra output port, 16 bits, reset 0) increments per dropped pixel.
- Not defined: no range check, every accepted pixel is emitted, and no clip_count port exists.

Decomposition:
- Shared package gpu_pixel_pkg holds:
  - pixel word field constants PIX_X_MSB=63, PIX_X_LSB=48, PIX_Y_MSB=47, PIX_Y_LSB=32, PIX_COLOUR_MSB=31;
  - default SCREEN_W/SCREEN_H;
  - the FSM state encoding (ARB_IDLE=0, ARB_GRANT=1).
- One sub-module, rr_pick: combinational rotated priority encoder with inputs req_valid and rr_ptr, outputs hit and index. It is reusable by the future texture-fetch arbiter.

Test Plan:
- Single source 0, 5 back-to-back pixels, full=0 -> 1 IDLE cycle, then 5 consecutive out_valid pulses, data equal to inputs in order, grant_id=0.
- All 3 valid continuously, BURST_MAX=4 -> grant sequence 0,1,2,0; exactly 4 pixels per burst; 1 gap cycle between bursts.
- out_fifo_full high for 10 cycles mid-burst -> req_ready low, no out_valid, burst_cnt frozen, grant held; resumes with the next pixel when full drops.
- Source 1 drops valid after 2 of 16 pixels while source 2 is valid -> release, rr_ptr=2, source 2 granted after 1 IDLE cycle.
- reset_n low for 1 cycle mid-burst -> next cycle out_valid=0, busy=0, grant_id=0; re-arbitration starts from source 0.
- CLIP_EN defined, SCREEN_W=640: pixel x=640,y=10 -> handshake completes, no out_valid, clip_count=1; pixel x=639,y=479 -> emitted.
